// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers.
// Each grant lasts until the requester's last word or MAXBURST words, whichever comes first.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int MAXBURST = 16,
    parameter int IDW      = 2
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state;
    logic [PW-1:0]       gidx;
    logic [PW-1:0]       rr_ptr;
    logic [CW-1:0]       burst_cnt;
    logic [PW-1:0]       pick_id;
    logic [PW-1:0]       cand;
    logic                pick_found;
    logic                burst_done;
    logic [DATASIZE-1:0] words [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = req_data[i*DATASIZE +: DATASIZE];
    end

    // Walk the ring from farthest to nearest so the last hit is the requester right after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = PW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Handshake: a word moves on a cycle where req_valid[g] & req_ready[g]; that is exactly winc.
    // Ready depends only on grant and wfull, never on valid, so producers may wait on it.
    always_comb begin
        req_ready  = '0;
        winc       = 1'b0;
        wdata      = words[gidx];
        burst_done = req_last[gidx] | (burst_cnt == CW'(MAXBURST - 1));
        if (state == BURST) begin
            req_ready = wfull ? '0 : (NREQ'(1'b1) << gidx);
            winc      = req_valid[gidx] & ~wfull;
        end
    end

    assign grant_id = IDW'(gidx);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state     <= IDLE;
            gidx      <= '0;
            burst_cnt <= '0;
            rr_ptr    <= PW'(NREQ - 1);
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gidx      <= pick_id;
                        burst_cnt <= '0;
                        state     <= BURST;
                        busy      <= 1'b1;
                    end
                end
                BURST: begin
                    if (winc) begin
                        if (burst_done) begin
                            rr_ptr    <= gidx;
                            burst_cnt <= '0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
